sample_injector: RTL and testbench

- Transmit end of the CRF traversal pipeline: accepts 256-bit samples from the host-side loader over a valid/ready handshake.
- Buffers accepted samples in a small FIFO.
- Launches at most one sample per cycle into stage 0 of the pipelineRegister chain, tagged with the root node index.
- Throttles launches against a maximum in-flight count, using retire pulses from the leaf end, and supports a drain sequence.

---
 rtl/crf_pipe_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 59 +++++
 rtl/sample_injector.sv | 158 +++++++++++++++
 tb/tb_sample_injector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/crf_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crf_pipe_pkg
// Description : Shared widths, root node constant and injector FSM encoding
//               for the CRF traversal pipeline.
// Revision    : 1.0
// ============================================================================
package crf_pipe_pkg;

  localparam int CRF_DATA_W    = 256;
  localparam int CRF_NODE_W    = 8;
  localparam int CRF_ROOT_NODE = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } inj_state_e;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : DEPTH x DATA_W synchronous FIFO, show-ahead head output.
// Revision    : 1.0
// ============================================================================
module sample_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/sample_injector.sv
`default_nettype none
// ============================================================================
// Module      : sample_injector
// Description : Buffers loader samples and launches them into pipeline stage 0,
//               throttled by an in-flight limit, with a drain sequence.
//               Define INJECT_STATS_EN to add launch/stall counter ports.
// Revision    : 1.0
// ============================================================================
module sample_injector
  import crf_pipe_pkg::*;
#(
  parameter int DATA_W       = CRF_DATA_W,
  parameter int NODE_W       = CRF_NODE_W,
  parameter int ROOT_NODE    = CRF_ROOT_NODE,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int TAG_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sampleData_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              retire_i,
  input  logic              drain_i,
  output logic [DATA_W-1:0] sampleData_o,
  output logic [NODE_W-1:0] nodeIndexOut,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [7:0]        inflight_o,
  output logic              done_o,
  output logic              err_o
`ifdef INJECT_STATS_EN
  ,
  output logic [31:0]       launch_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [7:0] MAX_IF = 8'(MAX_INFLIGHT);

  inj_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NODE_W-1:0] node_q, node_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [7:0]        inflight_q, inflight_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              under_limit;
  logic              launch;

  assign in_ready    = !rst && (state_q == ST_RUN) && !fifo_full;
  assign push        = in_valid && in_ready;
  assign under_limit = (inflight_q < MAX_IF);
  // Uses the registered FIFO state, so a sample pushed this edge waits one cycle.
  assign launch      = !fifo_empty && under_limit && (state_q != ST_DONE);

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (sampleData_i),
    .pop_i   (launch),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_i)                               state_d = ST_RUN;
        else if (fifo_empty && inflight_q == 8'd0)  state_d = ST_DONE;
      end
      ST_DONE:  if (!drain_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    data_d     = '0;
    node_d     = '0;
    valid_d    = 1'b0;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (launch) begin
      data_d  = fifo_head;
      node_d  = NODE_W'(ROOT_NODE);
      valid_d = 1'b1;
      tag_d   = tag_q + TAG_W'(1);
    end
    if (launch && !retire_i) begin
      inflight_d = inflight_q + 8'd1;
    end else if (retire_i && !launch) begin
      if (inflight_q == 8'd0) err_d = 1'b1;
      else                    inflight_d = inflight_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      data_q     <= '0;
      node_q     <= '0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      node_q     <= node_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sampleData_o = data_q;
  assign nodeIndexOut = node_q;
  assign valid_o      = valid_q;
  assign tag_o        = tag_q;
  assign inflight_o   = inflight_q;
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

`ifdef INJECT_STATS_EN
  logic [31:0] launch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      launch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (launch)                      launch_cnt_q <= launch_cnt_q + 32'd1;
      if (!fifo_empty && !under_limit) stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign launch_cnt_o = launch_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_injector
// Description : Directed vector table plus randomized run against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_sample_injector;

  localparam int DW    = 256;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          in_valid;
  logic          in_ready;
  logic          retire;
  logic          drain;
  logic [DW-1:0] dout;
  logic [7:0]    node;
  logic          valid;
  logic [3:0]    tag;
  logic [7:0]    inflight;
  logic          done;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sample_injector #(
    .DEPTH        (DEPTH),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sampleData_i (din),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .retire_i     (retire),
    .drain_i      (drain),
    .sampleData_o (dout),
    .nodeIndexOut (node),
    .valid_o      (valid),
    .tag_o        (tag),
    .inflight_o   (inflight),
    .done_o       (done),
    .err_o        (err)
  );

  typedef struct {
    bit            r, iv, ret, drn;
    logic [DW-1:0] d;
    bit            ev;
    logic [DW-1:0] ed;
    logic [3:0]    etag;
    logic [7:0]    einf;
    bit            erdy, edone, eerr;
  } vec_t;

  function automatic vec_t V(bit r, bit iv, logic [DW-1:0] d, bit ret, bit drn,
                             bit ev, logic [DW-1:0] ed, int etag, int einf,
                             bit erdy, bit edone, bit eerr);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.ret = ret; v.drn = drn;
    v.ev = ev; v.ed = ed; v.etag = 4'(etag); v.einf = 8'(einf);
    v.erdy = erdy; v.edone = edone; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string pfx, bit ev, logic [DW-1:0] ed, logic [3:0] et,
                           logic [7:0] ei, bit erdy, bit edone, bit eerr);
    chk({pfx, " valid_o"}, DW'(valid), DW'(ev));
    chk({pfx, " sampleData_o"}, dout, ed);
    chk({pfx, " nodeIndexOut"}, DW'(node), '0);
    chk({pfx, " tag_o"}, DW'(tag), DW'(et));
    chk({pfx, " inflight_o"}, DW'(inflight), DW'(ei));
    chk({pfx, " in_ready"}, DW'(in_ready), DW'(erdy));
    chk({pfx, " done_o"}, DW'(done), DW'(edone));
    chk({pfx, " err_o"}, DW'(err), DW'(eerr));
  endtask

  // Behavioural model: queue of pending samples plus counters and mode flags.
  logic [DW-1:0] mq[$];
  int            m_inf, m_tag;
  bit            m_v, m_err, m_drain, m_done;
  logic [DW-1:0] m_d;

  function automatic void model_reset();
    mq.delete();
    m_inf = 0; m_tag = 0; m_v = 0; m_d = '0;
    m_err = 0; m_drain = 0; m_done = 0;
  endfunction

  function automatic void model_edge(bit r, bit iv, logic [DW-1:0] d, bit ret, bit drn);
    bit ready, launch;
    int size_pre, inf_pre;
    if (r) begin
      model_reset();
      return;
    end
    size_pre = mq.size();
    inf_pre  = m_inf;
    ready    = !m_drain && !m_done && (size_pre < DEPTH);
    launch   = (size_pre > 0) && (m_inf < MAXI) && !m_done;
    if (launch) begin
      m_d   = mq.pop_front();
      m_v   = 1;
      m_tag = (m_tag + 1) % 16;
    end else begin
      m_d = '0;
      m_v = 0;
    end
    if (iv && ready) mq.push_back(d);
    if (launch && !ret)      m_inf = m_inf + 1;
    else if (ret && !launch) begin
      if (m_inf == 0) m_err = 1;
      else            m_inf = m_inf - 1;
    end
    if (m_done) begin
      if (!drn) m_done = 0;
    end else if (m_drain) begin
      if (!drn) m_drain = 0;
      else if (size_pre == 0 && inf_pre == 0) begin
        m_drain = 0;
        m_done  = 1;
      end
    end else if (drn) begin
      m_drain = 1;
    end
  endfunction

  vec_t          tbl[31];
  logic [DW-1:0] F, A1, BAD, rd;
  bit            rr, riv, rret, rdrn;

  initial begin
    F   = {32{8'hF0}};
    A1  = 256'hA1;
    BAD = 256'hBAD;
    rst = 1'b1; din = '0; in_valid = 0; retire = 0; drain = 0;

    // reset, single sample, simultaneous launch+retire, throttle, drain, error
    tbl[0]  = V(1,0,'0,0,0, 0,'0,0,0,0,0,0);
    tbl[1]  = V(1,0,'0,0,0, 0,'0,0,0,0,0,0);
    tbl[2]  = V(0,0,'0,0,0, 0,'0,0,0,1,0,0);
    tbl[3]  = V(0,1,256'h300,0,0, 0,'0,0,0,1,0,0);
    tbl[4]  = V(0,0,'0,0,0, 1,256'h300,1,1,1,0,0);
    tbl[5]  = V(0,0,'0,0,0, 0,'0,1,1,1,0,0);
    tbl[6]  = V(0,1,A1,0,0, 0,'0,1,1,1,0,0);
    tbl[7]  = V(0,0,'0,1,0, 1,A1,2,1,1,0,0);
    tbl[8]  = V(0,1,F,0,0, 0,'0,2,1,1,0,0);
    tbl[9]  = V(0,1,F,0,0, 1,F,3,2,1,0,0);
    tbl[10] = V(0,1,F,0,0, 0,'0,3,2,1,0,0);
    tbl[11] = V(0,1,F,0,0, 0,'0,3,2,1,0,0);
    tbl[12] = V(0,1,F,0,0, 0,'0,3,2,0,0,0);
    tbl[13] = V(0,1,F,0,0, 0,'0,3,2,0,0,0);
    tbl[14] = V(0,1,F,1,0, 0,'0,3,1,0,0,0);
    tbl[15] = V(0,0,'0,0,0, 1,F,4,2,1,0,0);
    tbl[16] = V(0,0,'0,0,0, 0,'0,4,2,1,0,0);
    tbl[17] = V(0,0,'0,0,1, 0,'0,4,2,0,0,0);
    tbl[18] = V(0,1,BAD,1,1, 0,'0,4,1,0,0,0);
    tbl[19] = V(0,0,'0,0,1, 1,F,5,2,0,0,0);
    tbl[20] = V(0,0,'0,1,1, 0,'0,5,1,0,0,0);
    tbl[21] = V(0,0,'0,0,1, 1,F,6,2,0,0,0);
    tbl[22] = V(0,0,'0,1,1, 0,'0,6,1,0,0,0);
    tbl[23] = V(0,0,'0,0,1, 1,F,7,2,0,0,0);
    tbl[24] = V(0,0,'0,1,1, 0,'0,7,1,0,0,0);
    tbl[25] = V(0,0,'0,1,1, 0,'0,7,0,0,0,0);
    tbl[26] = V(0,0,'0,0,1, 0,'0,7,0,0,1,0);
    tbl[27] = V(0,0,'0,0,1, 0,'0,7,0,0,1,0);
    tbl[28] = V(0,0,'0,0,0, 0,'0,7,0,1,0,0);
    tbl[29] = V(0,0,'0,1,0, 0,'0,7,0,1,0,1);
    tbl[30] = V(0,0,'0,0,0, 0,'0,7,0,1,0,1);

    for (int i = 0; i < 31; i++) begin
      rst = tbl[i].r; in_valid = tbl[i].iv; din = tbl[i].d;
      retire = tbl[i].ret; drain = tbl[i].drn;
      step();
      check_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].etag,
                tbl[i].einf, tbl[i].erdy, tbl[i].edone, tbl[i].eerr);
    end

    // Tag wrap: one launch per cycle with a matching retire, tag runs 8..15,0..7.
    in_valid = 1; din = 256'd1000; retire = 0; drain = 0;
    step();
    check_all("wrap pre", 0, '0, 4'd7, 8'd0, 1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1; din = DW'(1001 + k); retire = (k > 0);
      step();
      check_all($sformatf("wrap%0d", k), 1, DW'(1000 + k), 4'((8 + k) % 16),
                8'd1, 1, 0, 1);
    end
    in_valid = 0; retire = 0;

    // Randomized run against the model, with occasional resets.
    rst = 1; model_reset();
    step(); step();
    rdrn = 0;
    for (int c = 0; c < 3000; c++) begin
      rr   = ($urandom_range(0, 199) == 0);
      riv  = ($urandom_range(0, 9) < 7);
      rd   = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      rret = (m_inf > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 49) == 0) rdrn = !rdrn;
      rst = rr; in_valid = riv; din = rd; retire = rret; drain = rdrn;
      model_edge(rr, riv, rd, rret, rdrn);
      step();
      check_all($sformatf("rand%0d", c), m_v, m_d, 4'(m_tag), 8'(m_inf),
                !rr && !m_drain && !m_done && (mq.size() < DEPTH), m_done, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
